// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver.
//   - Segment patterns {g,f,e,d,c,b,a}, active-high.
//   - Mode codes carried in state_info[2:0].
//   - Bit positions of the BCD fields inside the packed time word.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [2:0] {
    MODE_IDLE   = 3'd0,
    MODE_SET    = 3'd1,
    MODE_ALARM  = 3'd2,
    MODE_TIMING = 3'd3,
    MODE_SELECT = 3'd4
  } mode_t;

  // LSB positions of the fields in time_data.
  localparam int SEC_L_LSB = 0;   // 4 bits
  localparam int SEC_H_LSB = 4;   // 3 bits
  localparam int MIN_L_LSB = 7;   // 4 bits
  localparam int MIN_H_LSB = 11;  // 3 bits
  localparam int HOU_L_LSB = 14;  // 4 bits
  localparam int HOU_H_LSB = 18;  // 2 bits

endpackage

// File: rtl/bcd_to_seg.sv
// BCD digit to seven-segment pattern.
//   bcd : 4-bit value
//   seg : {g,f,e,d,c,b,a}; values above 9 show a dash
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for two 4-digit common-cathode displays.
//   clk_sys, rst      : clock, asynchronous active-high reset
//   time_data [19:0]  : packed BCD hh:mm:ss, sampled once per scan frame
//   state_info [5:0]  : [2:0] mode, [5:3] detail, sampled once per frame
//   blink_en, blink_pos: blank one time digit during the off blink phase
//   led0/led1         : segments of group 0 (mm:ss) / group 1 (hh, detail, mode)
//   led_mux0/led_mux1 : one-hot digit enables, both groups share the index
//   dp0/dp1           : decimal points (minutes|seconds, hours|minutes)
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int BLINK_HZ = 2
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic [19:0] time_data,
  input  logic [5:0]  state_info,
  input  logic        blink_en,
  input  logic [2:0]  blink_pos,
  output logic [6:0]  led0,
  output logic [6:0]  led1,
  output logic [3:0]  led_mux0,
  output logic [3:0]  led_mux1,
  output logic        dp0,
  output logic        dp1
);

  localparam int DIV  = CLK_HZ / SCAN_HZ;
  localparam int HALF = SCAN_HZ / (2 * BLINK_HZ);
  localparam int PW   = (DIV  > 1) ? $clog2(DIV)  : 1;
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(HALF - 1);

  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [BW-1:0] blink_cnt;
  logic          phase;
  logic [19:0]   shadow_time;
  logic [5:0]    shadow_status;
  logic          tick;

  assign tick = (presc == PRESC_MAX);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would make results depend on block order.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      presc         <= '0;
      idx           <= '0;
      blink_cnt     <= '0;
      phase         <= 1'b1;
      shadow_time   <= '0;
      shadow_status <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        idx <= idx + 2'd1;
        // Frame boundary: latch inputs so a whole frame shows one snapshot.
        if (idx == 2'd3) begin
          shadow_time   <= time_data;
          shadow_status <= state_info;
        end
        if (blink_cnt == BLINK_MAX) begin
          blink_cnt <= '0;
          phase     <= ~phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  // Digit selection for the current index.
  logic [3:0] g0_val, g1_val;
  logic       g1_status_blank;
  logic       g0_blink, g1_blink;
  logic       blink_off;
  logic [2:0] mode_code;

  assign mode_code = shadow_status[2:0];
  assign blink_off = blink_en && !phase;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    g0_val          = '0;
    g1_val          = '0;
    g1_status_blank = 1'b0;
    g1_blink        = 1'b0;
    unique case (idx)
      2'd0: begin
        g0_val   = shadow_time[SEC_L_LSB +: 4];
        g1_val   = shadow_time[HOU_L_LSB +: 4];
        g1_blink = (blink_pos == 3'd4);
      end
      2'd1: begin
        g0_val   = {1'b0, shadow_time[SEC_H_LSB +: 3]};
        g1_val   = {2'b0, shadow_time[HOU_H_LSB +: 2]};
        g1_blink = (blink_pos == 3'd5);
      end
      2'd2: begin
        g0_val          = shadow_time[MIN_L_LSB +: 4];
        g1_val          = {1'b0, shadow_status[5:3]};
        g1_status_blank = (shadow_status == 6'd0);
      end
      default: begin
        g0_val          = {1'b0, shadow_time[MIN_H_LSB +: 3]};
        // Undefined mode codes are pushed into the decoder's dash range.
        g1_val          = (mode_code > MODE_SELECT) ? 4'hA : {1'b0, mode_code};
        g1_status_blank = (shadow_status == 6'd0);
      end
    endcase
  end

  assign g0_blink = (blink_pos == {1'b0, idx});

  logic [6:0] g0_seg, g1_seg;

  bcd_to_seg u_dec0 (.bcd(g0_val), .seg(g0_seg));
  bcd_to_seg u_dec1 (.bcd(g1_val), .seg(g1_seg));

  // Segments, mux and dp all register on the same edge, so the enable and
  // the pattern can never disagree for a cycle.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      led0     <= '0;
      led1     <= '0;
      led_mux0 <= '0;
      led_mux1 <= '0;
      dp0      <= 1'b0;
      dp1      <= 1'b0;
    end else begin
      led0     <= (blink_off && g0_blink) ? SEG_BLANK : g0_seg;
      led1     <= ((blink_off && g1_blink) || g1_status_blank) ? SEG_BLANK : g1_seg;
      led_mux0 <= 4'b0001 << idx;
      led_mux1 <= 4'b0001 << idx;
      dp0      <= (idx == 2'd2);
      dp1      <= (idx == 2'd0);
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver. The reference model derives the
// expected display purely from elapsed clock count and the history of
// driven inputs: tick count = edges / DIV, frame snapshot = inputs at the
// edge that completed the last multiple-of-4 tick, blink phase from ticks.
module tb_seg_scan_driver;

  localparam int CLK_HZ   = 16;
  localparam int SCAN_HZ  = 4;
  localparam int BLINK_HZ = 1;
  localparam int DIV      = CLK_HZ / SCAN_HZ;
  localparam int HALF     = SCAN_HZ / (2 * BLINK_HZ);
  localparam int HMAX     = 1024;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic [19:0] time_data;
  logic [5:0]  state_info;
  logic        blink_en;
  logic [2:0]  blink_pos;
  logic [6:0]  led0, led1;
  logic [3:0]  led_mux0, led_mux1;
  logic        dp0, dp1;

  seg_scan_driver #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .BLINK_HZ(BLINK_HZ)) dut (
    .clk_sys(clk_sys), .rst(rst), .time_data(time_data), .state_info(state_info),
    .blink_en(blink_en), .blink_pos(blink_pos), .led0(led0), .led1(led1),
    .led_mux0(led_mux0), .led_mux1(led_mux1), .dp0(dp0), .dp1(dp1)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs as seen at edge number e (edges counted from reset release).
  logic [19:0] td_hist [HMAX];
  logic [5:0]  si_hist [HMAX];
  logic        be_hist [HMAX];
  logic [2:0]  bp_hist [HMAX];

  function automatic logic [19:0] pack_time(input int hh, input int hl, input int mh,
                                            input int ml, input int sh, input int sl);
    return (20'(hh) << 18) | (20'(hl) << 14) | (20'(mh) << 11) |
           (20'(ml) << 7)  | (20'(sh) << 4)  | 20'(sl);
  endfunction

  function automatic logic [6:0] seg_of(input int v);
    logic [6:0] tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return (v <= 9) ? tbl[v] : 7'h40;
  endfunction

  // Expected {led1, led0, mux1, mux0, dp1, dp0} right after edge k.
  function automatic logic [23:0] model(input int k);
    int ticks, idx, ft, g0[4];
    bit phase_on;
    logic [19:0] td;
    logic [5:0] si;
    logic [6:0] s0, s1;
    logic [3:0] mux;
    if (k == 0) return '0;
    ticks    = (k - 1) / DIV;          // outputs lag the state by one edge
    idx      = ticks % 4;
    phase_on = ((ticks / HALF) % 2) == 0;
    ft       = (ticks / 4) * 4;
    td       = (ft == 0) ? 20'd0 : td_hist[ft * DIV];
    si       = (ft == 0) ? 6'd0  : si_hist[ft * DIV];
    g0[0] = int'(td[3:0]);   g0[1] = int'(td[6:4]);
    g0[2] = int'(td[10:7]);  g0[3] = int'(td[13:11]);
    s0 = seg_of(g0[idx]);
    case (idx)
      0:       s1 = seg_of(int'(td[17:14]));
      1:       s1 = seg_of(int'(td[19:18]));
      2:       s1 = (si == 0) ? 7'h00 : seg_of(int'(si[5:3]));
      default: s1 = (si == 0) ? 7'h00 : (si[2:0] > 3'd4 ? 7'h40 : seg_of(int'(si[2:0])));
    endcase
    if (be_hist[k] && !phase_on) begin
      if (int'(bp_hist[k]) == idx) s0 = 7'h00;
      if (idx < 2 && int'(bp_hist[k]) == idx + 4) s1 = 7'h00;
    end
    mux = 4'(1 << idx);
    return {s1, s0, mux, mux, idx == 0, idx == 2};
  endfunction

  logic [19:0] t123456;

  // Drive inputs for edge e following the directed/random schedule.
  task automatic drive(input int e, input bit rand_only);
    if (rand_only || e >= 300) begin
      if (e % 8 == 0) begin
        time_data  = 20'($urandom());
        state_info = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom());
        blink_en   = 1'($urandom());
        blink_pos  = 3'($urandom());
      end
    end else if (e < 37) begin
      time_data = t123456; state_info = 6'd0; blink_en = 1'b0; blink_pos = 3'd0;
    end else if (e < 100) begin
      time_data = 20'd0;                      // changes mid-frame at index 1
    end else if (e < 180) begin
      time_data = t123456; blink_en = 1'b1; blink_pos = 3'd0;
    end else if (e < 220) begin
      state_info = 6'b011_010;
    end else if (e < 260) begin
      state_info = 6'b011_111;
    end else begin
      time_data = pack_time(1, 2, 3, 4, 5, 12);
    end
    td_hist[e] = time_data;
    si_hist[e] = state_info;
    be_hist[e] = blink_en;
    bp_hist[e] = blink_pos;
  endtask

  function automatic logic [23:0] outs();
    return {led1, led0, led_mux1, led_mux0, dp1, dp0};
  endfunction

  int k;

  initial begin
    t123456    = pack_time(1, 2, 3, 4, 5, 6);
    rst        = 1'b1;
    time_data  = '0;
    state_info = '0;
    blink_en   = 1'b0;
    blink_pos  = '0;
    repeat (3) @(posedge clk_sys);
    #1 check("reset_outs", 32'(outs()), 32'd0);

    // Run 1: directed segments followed by random inputs.
    @(negedge clk_sys);
    rst = 1'b0;
    k   = 0;
    for (int c = 0; c < 700; c++) begin
      drive(k + 1, 1'b0);
      @(posedge clk_sys);
      k++;
      #1 check($sformatf("run1_k%0d", k), 32'(outs()), 32'(model(k)));
      @(negedge clk_sys);
    end

    // Spot checks on the directed section's known values.
    check("frame1_idx0_led0", 32'(model(4 * DIV + 1) >> 10 & 24'h7F), 32'h7D);

    // Advance until the index (state after k edges) is 3, then reset mid-frame.
    for (int c = 0; c < 4 * DIV && ((k / DIV) % 4) != 3; c++) begin
      drive(k + 1, 1'b1);
      @(posedge clk_sys);
      k++;
      #1 check($sformatf("align_k%0d", k), 32'(outs()), 32'(model(k)));
      @(negedge clk_sys);
    end
    check("idx_at_3", 32'((k / DIV) % 4), 32'd3);
    rst = 1'b1;
    #1 check("rst_async", 32'(outs()), 32'd0);
    @(posedge clk_sys);
    #1 check("rst_held", 32'(outs()), 32'd0);
    @(negedge clk_sys);
    rst = 1'b0;
    k   = 0;
    time_data = 20'($urandom());           // ignored until the first wrap
    state_info = 6'($urandom());
    for (int c = 0; c < 80; c++) begin
      drive(k + 1, 1'b1);
      @(posedge clk_sys);
      k++;
      #1;
      if (k == 1) begin
        check("post_rst_led0", 32'(led0), 32'h3F);
        check("post_rst_mux0", 32'(led_mux0), 32'h1);
        check("post_rst_dp0", 32'(dp0), 32'd0);
      end
      check($sformatf("run2_k%0d", k), 32'(outs()), 32'(model(k)));
      @(negedge clk_sys);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
